posi_satd_cost_accum: RTL

- Second (vertical) half of the post-intra SATD cost datapath.
- Sits directly downstream of the row-wise Hadamard engine and consumes its 8-lane row-transformed output.
- Buffers one 4x4 or 8x8 block of rows, runs the column Hadamard one column per cycle, and accumulates absolute coefficients.
- Emits one normalized SATD cost per block to the post-intra mode decision.

---
 rtl/posi_satd_cost_accum_if.sv | 36 +++
 rtl/posi_satd_cost_accum.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/posi_satd_cost_accum_if.sv
// Handshake and data bundle between the row Hadamard engine and the
// column SATD accumulator; err_o exists only with POSI_SATD_DROP_CHK_EN.
interface posi_satd_cost_accum_if #(
    parameter int DATA_WIDTH = 9
);
    localparam int IN_W   = DATA_WIDTH + 3;
    localparam int COST_W = DATA_WIDTH + 12;

    logic [1:0]          size_i;
    logic                val_i;
    logic [IN_W*8-1:0]   dat_i;
    logic                rdy_o;
    logic                val_o;
    logic [COST_W-1:0]   cost_o;
`ifdef POSI_SATD_DROP_CHK_EN
    logic                err_o;

    modport master (
        output size_i, val_i, dat_i,
        input  rdy_o, val_o, cost_o, err_o
    );
    modport slave (
        input  size_i, val_i, dat_i,
        output rdy_o, val_o, cost_o, err_o
    );
`else
    modport master (
        output size_i, val_i, dat_i,
        input  rdy_o, val_o, cost_o
    );
    modport slave (
        input  size_i, val_i, dat_i,
        output rdy_o, val_o, cost_o
    );
`endif
endinterface

// File: rtl/posi_satd_cost_accum.sv
// Column Hadamard + |coef| accumulator producing one SATD cost per 4x4/8x8 block.
// Optional dropped-beat flag err_o when POSI_SATD_DROP_CHK_EN is defined.
`ifndef SIZE_04
`define SIZE_04 2'd0
`endif

module posi_satd_cost_accum #(
    parameter int DATA_WIDTH = 9
) (
    input logic                    clk,
    input logic                    rstn,
    posi_satd_cost_accum_if.slave  bus
);
    localparam int IN_W   = DATA_WIDTH + 3;
    localparam int COL_W  = IN_W + 3;
    localparam int COST_W = DATA_WIDTH + 12;
    localparam int ACC_W  = COL_W + 6;
    localparam int SUM_W  = COL_W + 3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]          beat_q;
    logic [2:0]          col_q;
    logic                is4_q;
    logic [ACC_W-1:0]    acc_q;
    logic                val_q;
    logic [COST_W-1:0]   cost_q;
    logic [COST_W-1:0]   cost_d;
    logic [ACC_W:0]      rnd;
    logic [IN_W*8-1:0]   rows_q [8];

    logic                take;
    logic                blk4;
    logic                last_beat;
    logic                col_last;

    logic signed [COL_W-1:0] x  [8];
    logic signed [COL_W-1:0] s1 [8];
    logic signed [COL_W-1:0] s2 [8];
    logic signed [COL_W-1:0] s3 [8];
    logic [SUM_W-1:0]        col_sum;

    function automatic logic [IN_W-1:0] lane(
        input logic [IN_W*8-1:0] row,
        input int                j
    );
        return row[IN_W*(7-j) +: IN_W];
    endfunction

    function automatic logic signed [COL_W-1:0] sx(
        input logic [IN_W-1:0] v
    );
        return {{(COL_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    function automatic logic [COL_W-1:0] mag(
        input logic signed [COL_W-1:0] v
    );
        return v[COL_W-1] ? -v : v;
    endfunction

    assign take      = (state_q == LOAD) && bus.val_i;
    assign blk4      = (beat_q == 3'd0) ? (bus.size_i == `SIZE_04) : is4_q;
    assign last_beat = blk4 ? (beat_q == 3'd1) : (beat_q == 3'd7);
    assign col_last  = is4_q ? (col_q == 3'd3) : (col_q == 3'd7);

    // Gather column col_q as signed samples; 4x4 packs two rows per beat.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            x[r] = '0;
        end
        if (is4_q) begin
            x[0] = sx(lane(rows_q[0], int'(col_q[1:0])));
            x[1] = sx(lane(rows_q[0], int'(col_q[1:0]) + 4));
            x[2] = sx(lane(rows_q[1], int'(col_q[1:0])));
            x[3] = sx(lane(rows_q[1], int'(col_q[1:0]) + 4));
        end else begin
            for (int r = 0; r < 8; r++) begin
                x[r] = sx(lane(rows_q[r], int'(col_q)));
            end
        end
    end

    // Butterfly stages; s2[0..3] is the 4-point result, s3 the 8-point one.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s1[2*k]   = x[2*k] + x[2*k+1];
            s1[2*k+1] = x[2*k] - x[2*k+1];
        end
        for (int g = 0; g < 8; g += 4) begin
            for (int i = 0; i < 2; i++) begin
                s2[g+i]   = s1[g+i] + s1[g+i+2];
                s2[g+i+2] = s1[g+i] - s1[g+i+2];
            end
        end
        for (int i = 0; i < 4; i++) begin
            s3[i]   = s2[i] + s2[i+4];
            s3[i+4] = s2[i] - s2[i+4];
        end
    end

    // Sum of absolute transform outputs for the current column.
    always_comb begin
        col_sum = '0;
        if (is4_q) begin
            for (int i = 0; i < 4; i++) begin
                col_sum = col_sum + SUM_W'(mag(s2[i]));
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                col_sum = col_sum + SUM_W'(mag(s3[i]));
            end
        end
    end

    // Rounded normalisation: /2 for 4x4, /4 for 8x8.
    always_comb begin
        if (is4_q) begin
            rnd = ({1'b0, acc_q} + (ACC_W+1)'(1)) >> 1;
        end else begin
            rnd = ({1'b0, acc_q} + (ACC_W+1)'(2)) >> 2;
        end
        cost_d = rnd[COST_W-1:0];
    end

    // Next-state logic for the LOAD -> COL -> DONE sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (take && last_beat) state_d = COL;
            COL:     if (col_last) state_d = DONE;
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= LOAD;
        else       state_q <= state_d;
    end

    // Counters, size latch, accumulator and registered result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q <= '0;
            col_q  <= '0;
            is4_q  <= 1'b0;
            acc_q  <= '0;
            val_q  <= 1'b0;
            cost_q <= '0;
        end else begin
            val_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (take) begin
                        if (beat_q == 3'd0) is4_q <= (bus.size_i == `SIZE_04);
                        beat_q <= beat_q + 3'd1;
                        if (last_beat) begin
                            col_q <= '0;
                            acc_q <= '0;
                        end
                    end
                end
                COL: begin
                    acc_q <= acc_q + ACC_W'(col_sum);
                    col_q <= col_q + 3'd1;
                end
                DONE: begin
                    val_q  <= 1'b1;
                    cost_q <= cost_d;
                    beat_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Row buffer holds raw beats; stale contents are harmless.
    always_ff @(posedge clk) begin
        if (take) rows_q[beat_q] <= bus.dat_i;
    end

    assign bus.rdy_o  = (state_q == LOAD);
    assign bus.val_o  = val_q;
    assign bus.cost_o = cost_q;

`ifdef POSI_SATD_DROP_CHK_EN
    logic err_q;

    // Sticky flag for beats offered while busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                           err_q <= 1'b0;
        else if (bus.val_i && !bus.rdy_o)    err_q <= 1'b1;
    end

    assign bus.err_o = err_q;

`ifdef H265_DEBUG
    // Debug-only notice when a beat is dropped.
    always_ff @(posedge clk) begin
        if (rstn && bus.val_i && !bus.rdy_o)
            $warning("posi_satd_cost_accum: beat dropped while busy");
    end
`endif
`endif

endmodule
